cache_controller: RTL and testbench

Sequencing controller for the 2-way, 64-set, 64-bit-line data cache. It sits between the MEM stage and the SRAM controller. Read hits are served from the cache in zero extra cycles. Read misses fetch a 64-bit line from SRAM, fill it into the LRU way as two word writes and flip LRU. Writes are write-through / no-write-allocate: any hit line is invalidated and the word is written to SRAM.

---
 rtl/cache_controller.sv | 160 ++++++++++++++++
 tb/tb_cache_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Purpose  : Sequencing controller between the MEM stage and the SRAM
//            controller for the 2-way, 64-set, 64-bit-line data cache.
//            Reads are served on a hit or filled on a miss; writes are
//            write-through and do not allocate. Define ARM_CACHE_EN to
//            enable the cache. Without it, every access bypasses to SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int ADDR_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [18:0] cache_address,
    output logic [31:0] cache_wdata,
    output logic        cache_w_en,
    output logic        invalidate,
    output logic        change_LRU,
    input  logic        hit,
    input  logic [31:0] cache_rdata,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam logic [31:0] c_addr_base = 32'(ADDR_BASE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_FILL_LO = 3'd2,
        S_FILL_HI = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] w_offset;
    logic        w_hit;

    assign w_offset     = address - c_addr_base;
    assign sram_address = w_offset;
    assign sram_wdata   = wdata;

`ifdef ARM_CACHE_EN
    localparam state_t c_rd_done = S_FILL_LO;
    logic [63:0] r_line;
    assign w_hit = hit;
`else
    localparam state_t c_rd_done = S_IDLE;
    logic w_unused_bypass;
    assign w_hit           = 1'b0;
    assign w_unused_bypass = hit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
`ifdef ARM_CACHE_EN
            r_line  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The write path wins when both requests are raised.
                    if (mem_w_en)
                        r_state <= S_WR_WAIT;
                    else if (mem_r_en && !w_hit)
                        r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (sram_ready) begin
                        r_state <= c_rd_done;
`ifdef ARM_CACHE_EN
                        r_line  <= sram_rdata;
`endif
                    end
                end
                S_FILL_LO: r_state <= S_FILL_HI;
                S_FILL_HI: r_state <= S_IDLE;
                S_WR_WAIT: begin
                    if (sram_ready)
                        r_state <= S_IDLE;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready         = 1'b0;
        rdata         = '0;
        cache_address = w_offset[18:0];
        cache_wdata   = '0;
        cache_w_en    = 1'b0;
        invalidate    = 1'b0;
        change_LRU    = 1'b0;
        sram_r_en     = 1'b0;
        sram_w_en     = 1'b0;
        // Held in reset the pipeline must not stall and nothing may be issued.
        if (!rst) begin
            ready = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_w_en) begin
                        invalidate = w_hit;
                    end else if (mem_r_en) begin
                        ready = w_hit;
                        if (w_hit)
                            rdata = cache_rdata;
                    end else begin
                        ready = 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    sram_r_en = 1'b1;
`ifndef ARM_CACHE_EN
                    if (sram_ready) begin
                        ready = 1'b1;
                        rdata = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                    end
`endif
                end
`ifdef ARM_CACHE_EN
                S_FILL_LO: begin
                    cache_w_en       = 1'b1;
                    cache_wdata      = r_line[31:0];
                    cache_address[2] = 1'b0;
                end
                S_FILL_HI: begin
                    cache_w_en       = 1'b1;
                    change_LRU       = 1'b1;
                    cache_wdata      = r_line[63:32];
                    cache_address[2] = 1'b1;
                    ready            = 1'b1;
                    rdata            = address[2] ? r_line[63:32] : r_line[31:0];
                end
`endif
                S_WR_WAIT: begin
                    sram_w_en = 1'b1;
                    ready     = sram_ready;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Purpose  : Directed self-checking bench for cache_controller; expectations
//            follow the build (ARM_CACHE_EN defined or not).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

`ifdef ARM_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [18:0] cache_address;
    logic [31:0] cache_wdata;
    logic        cache_w_en;
    logic        invalidate;
    logic        change_LRU;
    logic        hit = 1'b0;
    logic [31:0] cache_rdata = '0;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    cache_controller #(.ADDR_BASE(1024)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_wdata(cache_wdata),
        .cache_w_en(cache_w_en), .invalidate(invalidate), .change_LRU(change_LRU),
        .hit(hit), .cache_rdata(cache_rdata),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0; hit = 1'b0; sram_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready"}, ready, 1);
        check_eq({tag, "_sram_r_en"}, sram_r_en, 0);
        check_eq({tag, "_sram_w_en"}, sram_w_en, 0);
    endtask

    // Read that goes to SRAM; the line is returned after n SRAM cycles.
    task automatic read_miss(input string tag, input logic [31:0] addr, input logic [63:0] line,
                             input int n, input logic hit_in, input logic [31:0] exp_rdata);
        int          cyc_cnt, ren_cnt, wen_cnt, lru_cnt;
        logic        done;
        logic [18:0] off;
        off = 19'(addr - 32'd1024);
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = addr; hit = hit_in;
        cache_rdata = 32'hDEAD_BEEF; sram_ready = 1'b0; sram_rdata = 64'h5555_5555_5555_5555;
        cyc_cnt = 0; ren_cnt = 0; wen_cnt = 0; lru_cnt = 0; done = 1'b0;
        while (!done && cyc_cnt < 40) begin
            @(negedge clk);
            cyc_cnt++;
            if (sram_r_en)  ren_cnt++;
            if (cache_w_en) begin
                wen_cnt++;
                check_eq({tag, "_fill_data"}, cache_wdata, (wen_cnt == 1) ? line[31:0] : line[63:32]);
                check_eq({tag, "_fill_addr"}, cache_address, (wen_cnt == 1) ? (off & ~19'h4) : (off | 19'h4));
                check_eq({tag, "_fill_no_inv"}, invalidate, 0);
            end
            if (change_LRU) lru_cnt++;
            if (ready) begin
                done = 1'b1;
                check_eq({tag, "_rdata"}, rdata, exp_rdata);
            end else begin
                check_eq({tag, "_stall_rdata"}, rdata, 0);
                @(posedge clk); #1;
                sram_ready = (ren_cnt == n - 1);
                sram_rdata = sram_ready ? line : 64'h5555_5555_5555_5555;
            end
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_latency"}, cyc_cnt, CACHE_ON ? n + 3 : n + 1);
        check_eq({tag, "_sram_r_cycles"}, ren_cnt, n);
        check_eq({tag, "_cache_w_cnt"}, wen_cnt, CACHE_ON ? 2 : 0);
        check_eq({tag, "_lru_cnt"}, lru_cnt, CACHE_ON ? 1 : 0);
    endtask

    task automatic write_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input int n, input logic hit_in, input logic exp_inv);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b1; address = addr; wdata = data;
        hit = hit_in; sram_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_inv"}, invalidate, exp_inv);
        check_eq({tag, "_req_ready"}, ready, 0);
        check_eq({tag, "_req_cache_w"}, cache_w_en, 0);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            sram_ready = (i == n);
            hit = 1'b0;
            @(negedge clk);
            check_eq({tag, "_sram_w_en"}, sram_w_en, 1);
            check_eq({tag, "_sram_addr"}, sram_address, addr - 32'd1024);
            check_eq({tag, "_sram_wdata"}, sram_wdata, data);
            check_eq({tag, "_ready"}, ready, (i == n) ? 1 : 0);
            check_eq({tag, "_no_cache_w"}, cache_w_en | invalidate, 0);
        end
    endtask

    task automatic reset_mid_read();
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'h408; hit = 1'b0; sram_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check_eq("rst_mid_pre_ren", sram_r_en, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_ren_drop", sram_r_en, 0);
        check_eq("rst_mid_ready", ready, 1);
        @(posedge clk); #1;
        mem_r_en = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_mid_no_fill", cache_w_en, 0);
            check_eq("rst_mid_idle_ren", sram_r_en, 0);
            check_eq("rst_mid_idle_ready", ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset held with a read request pending.
        mem_r_en = 1'b1; address = 32'h408; hit = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_sram_en", {sram_r_en, sram_w_en}, 0);
        check_eq("rst_cache_ctl", {cache_w_en, invalidate, change_LRU}, 0);
        check_eq("rst_cache_addr", cache_address, 19'h8);
        @(posedge clk); #1;
        mem_r_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", ready, 1);
        check_eq("post_rst_sram_r", sram_r_en, 0);

        // A stray SRAM completion in IDLE changes nothing.
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        check_eq("stray_ready", ready, 1);
        idle_cycle("stray_after");

        read_miss("miss408", 32'h408, 64'hBBBB_0002_AAAA_0001, 4, 1'b0, 32'hAAAA_0001);
`ifdef ARM_CACHE_EN
        // Back-to-back hit on the odd word of the line just filled.
        @(posedge clk); #1;
        mem_r_en = 1'b1; address = 32'h40C; hit = 1'b1; cache_rdata = 32'hBBBB_0002; sram_ready = 1'b0;
        @(negedge clk);
        check_eq("hit_ready", ready, 1);
        check_eq("hit_rdata", rdata, 32'hBBBB_0002);
        check_eq("hit_sram_r", sram_r_en, 0);
        check_eq("hit_cache_addr", cache_address, 19'hC);
        idle_cycle("hit_after");
`else
        // With the cache bypassed, hit is ignored and every read goes to SRAM.
        read_miss("byp_408b", 32'h408, 64'hBBBB_0002_AAAA_0001, 4, 1'b1, 32'hAAAA_0001);
`endif
        read_miss("miss40C", 32'h40C, 64'h0000_0004_0000_0003, 1, 1'b0, 32'h0000_0004);
        write_op("wr408", 32'h408, 32'h1234_5678, 3, 1'b1, CACHE_ON);
        read_miss("miss_after_wr", 32'h408, 64'h1111_2222_1234_5678, 2, 1'b0, 32'h1234_5678);
        idle_cycle("pre_rst_mid");
        reset_mid_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
